// File: rtl/ar_srl_fifo_lvl_pkg.sv
// Shared types and the watermark flag calculation for the SRL FIFO.
package ar_srl_fifo_lvl_pkg;

    // Widest count for l2depth=10; narrower counts are zero-extended into it.
    localparam int CNT_W_MAX = 11;

    typedef logic [CNT_W_MAX-1:0] cnt_ext_t;

    typedef struct packed {
        logic full_n;
        logic empty_n;
        logic afull;
        logic aempty;
    } flags_t;

    function automatic flags_t calc_flags(input cnt_ext_t cnt,
                                          input cnt_ext_t depth,
                                          input cnt_ext_t afull_lvl,
                                          input cnt_ext_t aempty_lvl);
        flags_t f;
        f.full_n  = (cnt != depth);
        f.empty_n = (cnt != '0);
        f.afull   = (cnt >= afull_lvl);
        f.aempty  = (cnt <= aempty_lvl);
        return f;
    endfunction

endpackage

// File: rtl/ar_srl_fifo_lvl_if.sv
// Enqueue/dequeue bus of the SRL FIFO; OVF/UNF exist only with AR_SRL_FIFO_ERR_EN.
`include "ar_fifo_defs.vh"

interface ar_srl_fifo_lvl_if #(
    parameter int width   = 128,
    parameter int l2depth = 5
);
    logic                                 CLR;
    logic                                 ENQ;
    logic                                 DEQ;
    logic [width-1:0]                     D_IN;
    logic [width-1:0]                     D_OUT;
    logic                                 FULL_N;
    logic                                 EMPTY_N;
    logic                                 ALMOST_FULL;
    logic                                 ALMOST_EMPTY;
    logic [`AR_FIFO_CNT_W(l2depth)-1:0]   COUNT;
`ifdef AR_SRL_FIFO_ERR_EN
    logic                                 OVF;
    logic                                 UNF;

    modport master (
        output CLR, ENQ, DEQ, D_IN,
        input  D_OUT, FULL_N, EMPTY_N, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVF, UNF
    );
    modport slave (
        input  CLR, ENQ, DEQ, D_IN,
        output D_OUT, FULL_N, EMPTY_N, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVF, UNF
    );
`else
    modport master (
        output CLR, ENQ, DEQ, D_IN,
        input  D_OUT, FULL_N, EMPTY_N, ALMOST_FULL, ALMOST_EMPTY, COUNT
    );
    modport slave (
        input  CLR, ENQ, DEQ, D_IN,
        output D_OUT, FULL_N, EMPTY_N, ALMOST_FULL, ALMOST_EMPTY, COUNT
    );
`endif
endinterface

// File: rtl/ar_fifo_defs.vh
// Shared FIFO helpers: count-width macro and elaboration-time parameter range checks.
`ifndef AR_FIFO_DEFS_VH
`define AR_FIFO_DEFS_VH

`define AR_FIFO_CNT_W(l2) ((l2) + 1)

`define AR_FIFO_PARAM_CHECK(L2, AF, AE) \
    if (((L2) < 1) || ((L2) > 10)) begin : g_bad_l2depth \
        $error("ar_fifo: l2depth %0d outside 1..10", (L2)); \
    end \
    if (((AF) < 1) || ((AF) > (1 << (L2)))) begin : g_bad_afull \
        $error("ar_fifo: afull_lvl %0d outside 1..depth", (AF)); \
    end \
    if (((AE) < 0) || ((AE) > ((1 << (L2)) - 1))) begin : g_bad_aempty \
        $error("ar_fifo: aempty_lvl %0d outside 0..depth-1", (AE)); \
    end

`endif

// File: rtl/ar_srl_shift.sv
// Shift-enable SRL storage with an addressed combinational read port; no reset so it maps onto SRL primitives.
// Latency: written word readable the cycle after the shift. No backpressure: the caller gates the shift enable.
module ar_srl_shift #(
    parameter int width   = 128,
    parameter int l2depth = 5
) (
    input  logic               clk,
    input  logic               shift_en,
    input  logic [width-1:0]   d,
    input  logic [l2depth-1:0] addr,
    output logic [width-1:0]   q
);
    localparam int DEPTH = 1 << l2depth;

    logic [width-1:0] srl_q [DEPTH];

    always_ff @(posedge clk) begin
        if (shift_en) begin
            srl_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                srl_q[i] <= srl_q[i-1];
            end
        end
    end

    assign q = srl_q[addr];

endmodule

// File: rtl/ar_srl_fifo_lvl.sv
// SRL FIFO with occupancy count and registered almost-full/almost-empty watermarks; optional sticky
// OVF/UNF flags under AR_SRL_FIFO_ERR_EN. FWFT, 1-cycle enqueue-to-D_OUT latency; ENQ ignored when full unless DEQ.
`include "ar_fifo_defs.vh"

module ar_srl_fifo_lvl
    import ar_srl_fifo_lvl_pkg::*;
#(
    parameter int width      = 128,
    parameter int l2depth    = 5,
    parameter int afull_lvl  = 28,
    parameter int aempty_lvl = 4
) (
    input  logic             CLK,
    input  logic             RST,
    ar_srl_fifo_lvl_if.slave bus
);
    localparam int       CW        = `AR_FIFO_CNT_W(l2depth);
    localparam int       DEPTH     = 1 << l2depth;
    localparam cnt_ext_t DEPTH_C   = cnt_ext_t'(DEPTH);
    localparam cnt_ext_t AFULL_C   = cnt_ext_t'(afull_lvl);
    localparam cnt_ext_t AEMPTY_C  = cnt_ext_t'(aempty_lvl);
    localparam flags_t   FLAGS_RST = calc_flags('0, DEPTH_C, AFULL_C, AEMPTY_C);

    `AR_FIFO_PARAM_CHECK(l2depth, afull_lvl, aempty_lvl)

    logic [CW-1:0]      count_q, count_d;
    flags_t             flags_q, flags_d;
    logic               enq_ok, deq_ok, shift_en;
    logic [l2depth-1:0] rd_addr;

    always_comb begin
        // A full FIFO may still take a word when the head leaves in the same cycle.
        enq_ok   = bus.ENQ & (flags_q.full_n | bus.DEQ);
        deq_ok   = bus.DEQ & flags_q.empty_n;
        shift_en = enq_ok & ~bus.CLR;
        count_d  = count_q;
        if (bus.CLR) begin
            count_d = '0;
        end else if (enq_ok & ~deq_ok) begin
            count_d = count_q + 1'b1;
        end else if (deq_ok & ~enq_ok) begin
            count_d = count_q - 1'b1;
        end
        flags_d = calc_flags(cnt_ext_t'(count_d), DEPTH_C, AFULL_C, AEMPTY_C);
    end

    // At count == depth the low bits are zero, so the wrap lands exactly on depth-1.
    assign rd_addr = count_q[l2depth-1:0] - 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
            flags_q <= FLAGS_RST;
        end else begin
            count_q <= count_d;
            flags_q <= flags_d;
        end
    end

`ifdef AR_SRL_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q | (bus.ENQ & ~enq_ok);
        unf_d = unf_q | (bus.DEQ & ~flags_q.empty_n);
        if (bus.CLR) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.OVF = ovf_q;
    assign bus.UNF = unf_q;
`endif

    ar_srl_shift #(
        .width   (width),
        .l2depth (l2depth)
    ) u_shift (
        .clk      (CLK),
        .shift_en (shift_en),
        .d        (bus.D_IN),
        .addr     (rd_addr),
        .q        (bus.D_OUT)
    );

    assign bus.COUNT        = count_q;
    assign bus.FULL_N       = flags_q.full_n;
    assign bus.EMPTY_N      = flags_q.empty_n;
    assign bus.ALMOST_FULL  = flags_q.afull;
    assign bus.ALMOST_EMPTY = flags_q.aempty;

endmodule

// File: tb/tb_ar_srl_fifo_lvl.sv
// Directed bench for ar_srl_fifo_lvl at width=8, depth=8, afull=6, aempty=1.
`timescale 1ns/1ps

module tb_ar_srl_fifo_lvl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    ar_srl_fifo_lvl_if #(.width(8), .l2depth(3)) bus ();

    ar_srl_fifo_lvl #(
        .width      (8),
        .l2depth    (3),
        .afull_lvl  (6),
        .aempty_lvl (1)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        bus.ENQ  = 1'b1;
        bus.D_IN = v;
        step();
        bus.ENQ  = 1'b0;
    endtask

    task automatic pop();
        bus.DEQ = 1'b1;
        step();
        bus.DEQ = 1'b0;
    endtask

    task automatic chk_idle_state(input string tag);
        chk({tag, "_count"},   32'(bus.COUNT), 0);
        chk({tag, "_empty_n"}, 32'(bus.EMPTY_N), 0);
        chk({tag, "_full_n"},  32'(bus.FULL_N), 1);
        chk({tag, "_aempty"},  32'(bus.ALMOST_EMPTY), 1);
        chk({tag, "_afull"},   32'(bus.ALMOST_FULL), 0);
    endtask

    initial begin
        bus.CLR  = 1'b0;
        bus.ENQ  = 1'b0;
        bus.DEQ  = 1'b0;
        bus.D_IN = '0;
        #12 rst = 1'b0;
        step();
        chk_idle_state("rst");

        // Fill 1..8: watermarks track the count with no lag.
        for (int v = 1; v <= 8; v++) begin
            push(8'(v));
            chk("fill_count",  32'(bus.COUNT), 32'(v));
            chk("fill_head",   32'(bus.D_OUT), 32'h01);
            chk("fill_full_n", 32'(bus.FULL_N), (v == 8) ? 0 : 1);
            chk("fill_afull",  32'(bus.ALMOST_FULL), (v >= 6) ? 1 : 0);
            chk("fill_aempty", 32'(bus.ALMOST_EMPTY), (v <= 1) ? 1 : 0);
        end

        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", 32'(bus.D_OUT), 32'(i));
            pop();
            chk("drain_count",   32'(bus.COUNT), 32'(8 - i));
            chk("drain_empty_n", 32'(bus.EMPTY_N), (i == 8) ? 0 : 1);
            chk("drain_aempty",  32'(bus.ALMOST_EMPTY), (8 - i <= 1) ? 1 : 0);
            chk("drain_afull",   32'(bus.ALMOST_FULL), (8 - i >= 6) ? 1 : 0);
        end

        // Full ENQ+DEQ: both accepted, head advances, new word goes to the tail.
        for (int v = 1; v <= 8; v++) push(8'(v));
        bus.ENQ = 1'b1; bus.DEQ = 1'b1; bus.D_IN = 8'hA5;
        step();
        bus.ENQ = 1'b0; bus.DEQ = 1'b0;
        chk("fulldual_count",  32'(bus.COUNT), 8);
        chk("fulldual_full_n", 32'(bus.FULL_N), 0);
        for (int i = 2; i <= 9; i++) begin
            chk("fulldual_data", 32'(bus.D_OUT), (i == 9) ? 32'hA5 : 32'(i));
            pop();
        end
        chk("fulldual_drained", 32'(bus.COUNT), 0);

        // Empty ENQ+DEQ: only the enqueue lands.
        bus.ENQ = 1'b1; bus.DEQ = 1'b1; bus.D_IN = 8'h3C;
        step();
        bus.ENQ = 1'b0; bus.DEQ = 1'b0;
        chk("emptydual_count",   32'(bus.COUNT), 1);
        chk("emptydual_empty_n", 32'(bus.EMPTY_N), 1);
        chk("emptydual_data",    32'(bus.D_OUT), 32'h3C);
        pop();
        chk("emptydual_drained", 32'(bus.COUNT), 0);

        // Overflow attempt at full, then underflow attempt at empty.
        for (int v = 1; v <= 8; v++) push(8'(8'h10 + v));
        push(8'hEE);
        chk("ovf_count",  32'(bus.COUNT), 8);
        chk("ovf_full_n", 32'(bus.FULL_N), 0);
`ifdef AR_SRL_FIFO_ERR_EN
        chk("ovf_flag",   32'(bus.OVF), 1);
        chk("ovf_unf_lo", 32'(bus.UNF), 0);
`endif
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_contents", 32'(bus.D_OUT), 32'(8'h10 + i));
            pop();
        end
        pop();
        chk("unf_count",   32'(bus.COUNT), 0);
        chk("unf_empty_n", 32'(bus.EMPTY_N), 0);
`ifdef AR_SRL_FIFO_ERR_EN
        chk("unf_flag",    32'(bus.UNF), 1);
        chk("unf_ovf_hold", 32'(bus.OVF), 1);
        bus.CLR = 1'b1;
        step();
        bus.CLR = 1'b0;
        chk("clr_ovf", 32'(bus.OVF), 0);
        chk("clr_unf", 32'(bus.UNF), 0);
`endif

        // CLR with 5 loaded, ENQ in the same cycle loses to CLR.
        for (int v = 1; v <= 5; v++) push(8'(8'h40 + v));
        chk("preclr_count", 32'(bus.COUNT), 5);
        bus.CLR = 1'b1; bus.ENQ = 1'b1; bus.D_IN = 8'h99;
        step();
        bus.CLR = 1'b0; bus.ENQ = 1'b0;
        chk_idle_state("clr");

        // Asynchronous reset mid-cycle with 5 loaded.
        for (int v = 1; v <= 5; v++) push(8'(8'h60 + v));
        chk("prerst_count", 32'(bus.COUNT), 5);
        #2 rst = 1'b1;
        #1;
        chk("arst_count",   32'(bus.COUNT), 0);
        chk("arst_empty_n", 32'(bus.EMPTY_N), 0);
        chk("arst_aempty",  32'(bus.ALMOST_EMPTY), 1);
        #2 rst = 1'b0;
        step();
        push(8'h77);
        chk("postrst_count", 32'(bus.COUNT), 1);
        chk("postrst_data",  32'(bus.D_OUT), 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
